// File: rtl/dm_port_arbiter_if.sv
// Request/response and RAM-side bundle for the data-memory port arbiter.
// The arbiter takes the slave view; requesters and the RAM model take the master view.
interface dm_port_arbiter_if;
  // Requester 0: pipeline load/store
  logic        r0_req;
  logic        r0_we;
  logic [3:0]  r0_be;
  logic [31:0] r0_addr;
  logic [31:0] r0_wdata;
  logic        r0_gnt;
  logic        r0_stall;
  logic        r0_rvalid;
  logic [31:0] r0_rdata;
  logic        r0_err;

  // Requester 1: DMA / debug master
  logic        r1_req;
  logic        r1_we;
  logic [3:0]  r1_be;
  logic [31:0] r1_addr;
  logic [31:0] r1_wdata;
  logic        r1_gnt;
  logic        r1_rvalid;
  logic [31:0] r1_rdata;
  logic        r1_err;

  // Single-port RAM, one-cycle read latency
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  modport slave (
    input  r0_req, r0_we, r0_be, r0_addr, r0_wdata,
    output r0_gnt, r0_stall, r0_rvalid, r0_rdata, r0_err,
    input  r1_req, r1_we, r1_be, r1_addr, r1_wdata,
    output r1_gnt, r1_rvalid, r1_rdata, r1_err,
    output mem_en, mem_we, mem_addr, mem_din,
    input  mem_dout
  );

  modport master (
    output r0_req, r0_we, r0_be, r0_addr, r0_wdata,
    input  r0_gnt, r0_stall, r0_rvalid, r0_rdata, r0_err,
    output r1_req, r1_we, r1_be, r1_addr, r1_wdata,
    input  r1_gnt, r1_rvalid, r1_rdata, r1_err,
    input  mem_en, mem_we, mem_addr, mem_din,
    output mem_dout
  );
endinterface

// File: rtl/dm_port_arbiter.sv
// Two-requester arbiter for the single-port data-memory RAM: combinational grant,
// starvation-bounded priority for the DMA port, range checking and read-return routing.
module dm_port_arbiter #(
  parameter logic [31:0] DM_LIMIT   = 32'h0000_3000,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic              clk,
  input logic              rst,
  dm_port_arbiter_if.slave bus
);

  localparam logic [3:0]  STARVE_MAX_C = 4'(STARVE_MAX);
  localparam logic [15:0] LIMIT_LO     = DM_LIMIT[15:0];

  typedef enum logic [1:0] {
    RD_IDLE = 2'b00,
    RD_OWN0 = 2'b01,
    RD_OWN1 = 2'b10
  } rd_state_e;

  rd_state_e   rd_state_q, rd_state_d;
  logic        rd_oor_q, rd_oor_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;

  logic        r0_win_s;
  logic        r1_win_s;
  logic        grant_s;
  logic        win_we_s;
  logic [3:0]  win_be_s;
  logic [31:0] win_addr_s;
  logic [31:0] win_wdata_s;
  logic        oor_s;
  logic        wr_err_s;
  logic [31:0] rd_data_s;
  logic        unused_addr_s;

  // Grant selection: DMA wins when the pipeline is idle or once it has waited STARVE_MAX cycles
  always_comb begin
    r0_win_s = 1'b0;
    r1_win_s = 1'b0;
    if (rst) begin
      r0_win_s = 1'b0;
      r1_win_s = 1'b0;
    end else if (bus.r1_req && (!bus.r0_req || (starve_cnt_q == STARVE_MAX_C))) begin
      r1_win_s = 1'b1;
    end else if (bus.r0_req) begin
      r0_win_s = 1'b1;
    end else begin
      r0_win_s = 1'b0;
      r1_win_s = 1'b0;
    end
  end

  // Winner request mux; requester 0 fields are passed through when nobody is granted
  always_comb begin
    win_we_s    = bus.r0_we;
    win_be_s    = bus.r0_be;
    win_addr_s  = bus.r0_addr;
    win_wdata_s = bus.r0_wdata;
    if (r1_win_s) begin
      win_we_s    = bus.r1_we;
      win_be_s    = bus.r1_be;
      win_addr_s  = bus.r1_addr;
      win_wdata_s = bus.r1_wdata;
    end else begin
      win_we_s    = bus.r0_we;
      win_be_s    = bus.r0_be;
      win_addr_s  = bus.r0_addr;
      win_wdata_s = bus.r0_wdata;
    end
  end

  assign grant_s       = r0_win_s | r1_win_s;
  assign oor_s         = (win_addr_s[15:0] >= LIMIT_LO);
  assign wr_err_s      = grant_s & win_we_s & oor_s;
  assign unused_addr_s = ^{win_addr_s[31:16], win_addr_s[1:0]};

  // RAM drive: out-of-range accesses are granted but never reach the array
  always_comb begin
    bus.mem_en   = 1'b0;
    bus.mem_we   = 4'b0000;
    bus.mem_addr = win_addr_s[13:2];
    bus.mem_din  = win_wdata_s;
    if (grant_s && !oor_s) begin
      bus.mem_en = 1'b1;
      if (win_we_s) begin
        bus.mem_we = win_be_s;
      end else begin
        bus.mem_we = 4'b0000;
      end
    end else begin
      bus.mem_en = 1'b0;
      bus.mem_we = 4'b0000;
    end
  end

  // Starvation counter: counts denied DMA cycles, saturates, clears on grant or idle
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (rst) begin
      starve_cnt_d = 4'd0;
    end else if (bus.r1_req && !r1_win_s) begin
      if (starve_cnt_q >= STARVE_MAX_C) begin
        starve_cnt_d = STARVE_MAX_C;
      end else begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
    end else begin
      starve_cnt_d = 4'd0;
    end
  end

  // Read-return tracker: remembers who owns the data arriving next cycle
  always_comb begin
    rd_state_d = RD_IDLE;
    rd_oor_d   = 1'b0;
    if (rst) begin
      rd_state_d = RD_IDLE;
      rd_oor_d   = 1'b0;
    end else if (grant_s && !win_we_s) begin
      if (r1_win_s) begin
        rd_state_d = RD_OWN1;
      end else begin
        rd_state_d = RD_OWN0;
      end
      rd_oor_d = oor_s;
    end else begin
      rd_state_d = RD_IDLE;
      rd_oor_d   = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q   <= RD_IDLE;
      rd_oor_q     <= 1'b0;
      starve_cnt_q <= 4'd0;
    end else begin
      rd_state_q   <= rd_state_d;
      rd_oor_q     <= rd_oor_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign rd_data_s = rd_oor_q ? 32'h0000_0000 : bus.mem_dout;

  // Response routing; a read in flight when reset rises is dropped without rvalid
  always_comb begin
    bus.r0_rvalid = 1'b0;
    bus.r1_rvalid = 1'b0;
    bus.r0_rdata  = 32'h0000_0000;
    bus.r1_rdata  = 32'h0000_0000;
    bus.r0_err    = r0_win_s & wr_err_s;
    bus.r1_err    = r1_win_s & wr_err_s;
    if (rst) begin
      bus.r0_rvalid = 1'b0;
      bus.r1_rvalid = 1'b0;
    end else begin
      case (rd_state_q)
        RD_OWN0: begin
          bus.r0_rvalid = 1'b1;
          bus.r0_rdata  = rd_data_s;
          bus.r0_err    = rd_oor_q | (r0_win_s & wr_err_s);
        end
        RD_OWN1: begin
          bus.r1_rvalid = 1'b1;
          bus.r1_rdata  = rd_data_s;
          bus.r1_err    = rd_oor_q | (r1_win_s & wr_err_s);
        end
        default: begin
          bus.r0_rvalid = 1'b0;
          bus.r1_rvalid = 1'b0;
        end
      endcase
    end
  end

  assign bus.r0_gnt   = r0_win_s;
  assign bus.r1_gnt   = r1_win_s;
  assign bus.r0_stall = bus.r0_req & ~r0_win_s;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter: a bench-side RAM, a per-cycle reference model
// of the arbitration/response rules, and hand-computed literal expectations.
module tb_dm_port_arbiter;
  localparam int unsigned STARVE_MAX = 4;
  localparam logic [31:0] DM_LIMIT   = 32'h0000_3000;

  logic clk = 1'b0;
  logic rst;

  dm_port_arbiter_if bus();

  dm_port_arbiter #(.DM_LIMIT(DM_LIMIT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEADBEEF;
    return 32'h1000_0000 + 32'(i);
  endfunction

  // Bench RAM: loads on the first clock, then behaves as a 1-cycle synchronous RAM
  logic [31:0] ram [0:4095];
  logic        ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 4096; i++) ram[i] <= init_word(i);
      ram_loaded <= 1'b1;
    end else if (bus.mem_en) begin
      bus.mem_dout <= ram[bus.mem_addr];
      for (int b = 0; b < 4; b++)
        if (bus.mem_we[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_din[8*b +: 8];
    end
  end

  // Reference model: memory image as "initial contents + writes seen so far"
  logic [31:0] m_wr [int];
  int          m_starve = 0;
  bit          m_pend = 1'b0;
  bit          m_pend_r1 = 1'b0;
  logic [31:0] m_pend_data = 32'h0;
  bit          m_pend_err = 1'b0;

  function automatic logic [31:0] m_read(input int w);
    if (m_wr.exists(w)) return m_wr[w];
    return init_word(w);
  endfunction

  always @(negedge clk) begin
    bit          e0, e1, g, we, oor, ev0, ev1;
    logic [3:0]  be;
    logic [31:0] a, wd, cur;
    int          w;
    e1  = !rst && bus.r1_req && (!bus.r0_req || m_starve == STARVE_MAX);
    e0  = !rst && bus.r0_req && !e1;
    g   = e0 || e1;
    we  = e1 ? bus.r1_we    : bus.r0_we;
    be  = e1 ? bus.r1_be    : bus.r0_be;
    a   = e1 ? bus.r1_addr  : bus.r0_addr;
    wd  = e1 ? bus.r1_wdata : bus.r0_wdata;
    oor = ({16'h0, a[15:0]} >= {16'h0, DM_LIMIT[15:0]});
    w   = int'(a[13:2]);
    ev0 = !rst && m_pend && !m_pend_r1;
    ev1 = !rst && m_pend && m_pend_r1;

    check("m_r0_gnt",    bus.r0_gnt,    e0);
    check("m_r1_gnt",    bus.r1_gnt,    e1);
    check("m_r0_stall",  bus.r0_stall,  bus.r0_req && !e0);
    check("m_mem_en",    bus.mem_en,    g && !oor);
    check("m_mem_we",    bus.mem_we,    (g && we && !oor) ? be : 4'b0000);
    check("m_r0_rvalid", bus.r0_rvalid, ev0);
    check("m_r1_rvalid", bus.r1_rvalid, ev1);
    check("m_r0_rdata",  bus.r0_rdata,  ev0 ? m_pend_data : 32'h0);
    check("m_r1_rdata",  bus.r1_rdata,  ev1 ? m_pend_data : 32'h0);
    check("m_r0_err",    bus.r0_err,    (ev0 && m_pend_err) || (e0 && we && oor));
    check("m_r1_err",    bus.r1_err,    (ev1 && m_pend_err) || (e1 && we && oor));
    if (g) begin
      check("m_mem_addr", bus.mem_addr, a[13:2]);
      check("m_mem_din",  bus.mem_din,  wd);
    end

    if (rst) begin
      m_starve = 0;
      m_pend   = 1'b0;
    end else begin
      if (bus.r1_req && !e1) m_starve = (m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1;
      else m_starve = 0;
      if (g && we && !oor) begin
        cur = m_read(w);
        for (int b = 0; b < 4; b++) if (be[b]) cur[8*b +: 8] = wd[8*b +: 8];
        m_wr[w] = cur;
      end
      m_pend      = g && !we;
      m_pend_r1   = e1;
      m_pend_err  = oor;
      m_pend_data = oor ? 32'h0 : m_read(w);
    end
  end

  task automatic set0(input logic req, input logic we, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wdata);
    bus.r0_req = req; bus.r0_we = we; bus.r0_be = be; bus.r0_addr = addr; bus.r0_wdata = wdata;
  endtask

  task automatic set1(input logic req, input logic we, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wdata);
    bus.r1_req = req; bus.r1_we = we; bus.r1_be = be; bus.r1_addr = addr; bus.r1_wdata = wdata;
  endtask

  task automatic idle();
    set0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    logic [9:0] r0v, r1v;
    logic [4:0] r1p;
    rst = 1'b1;
    idle();
    repeat (3) step();
    mid();
    check("rst_r0_rvalid", bus.r0_rvalid, 1'b0);
    check("rst_mem_en", bus.mem_en, 1'b0);
    step();
    rst = 1'b0;

    // Read word 4
    set0(1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
    mid();
    check("t1_gnt", bus.r0_gnt, 1'b1);
    check("t1_en", bus.mem_en, 1'b1);
    check("t1_addr", bus.mem_addr, 12'd4);
    check("t1_we", bus.mem_we, 4'b0000);
    step(); idle(); mid();
    check("t1_rvalid", bus.r0_rvalid, 1'b1);
    check("t1_rdata", bus.r0_rdata, 32'hDEADBEEF);

    // Byte-lane write then read back
    step(); set0(1'b1, 1'b1, 4'b0100, 32'h0000_0022, 32'h00AB_0000); mid();
    check("t2_we", bus.mem_we, 4'b0100);
    check("t2_addr", bus.mem_addr, 12'd8);
    check("t2_stall", bus.r0_stall, 1'b0);
    step(); idle(); mid();
    check("t2_no_rvalid", bus.r0_rvalid, 1'b0);
    step(); set0(1'b1, 1'b0, 4'hF, 32'h0000_0020, 32'h0); mid();
    step(); idle(); mid();
    check("t2_readback", bus.r0_rdata, 32'h10AB_0008);

    // Contention: DMA wins every fifth cycle
    for (int i = 0; i < 10; i++) begin
      step();
      set0(1'b1, 1'b0, 4'hF, 32'h0000_0030, 32'h0);
      set1(1'b1, 1'b0, 4'hF, 32'h0000_0044, 32'h0);
      mid();
      r0v[i] = bus.r0_gnt;
      r1v[i] = bus.r1_gnt;
      if (i == 4) check("t3_stall_c5", bus.r0_stall, 1'b1);
      if (i == 5) check("t3_r1_rdata", bus.r1_rdata, 32'h1000_0011);
    end
    check("t3_r1_pattern", r1v, 10'b1000010000);
    check("t3_r0_pattern", r0v, 10'b0111101111);
    step(); idle(); mid();

    // Range boundary and out-of-range accesses
    step(); set0(1'b1, 1'b0, 4'hF, 32'h0000_2FFC, 32'h0); mid();
    check("t4_edge_en", bus.mem_en, 1'b1);
    check("t4_edge_addr", bus.mem_addr, 12'hBFF);
    step(); set0(1'b1, 1'b0, 4'hF, 32'h0000_3004, 32'h0); mid();
    check("t4_rd_gnt", bus.r0_gnt, 1'b1);
    check("t4_rd_en", bus.mem_en, 1'b0);
    step(); idle(); mid();
    check("t4_rd_rvalid", bus.r0_rvalid, 1'b1);
    check("t4_rd_err", bus.r0_err, 1'b1);
    check("t4_rd_rdata", bus.r0_rdata, 32'h0);
    step(); set0(1'b1, 1'b1, 4'hF, 32'h0000_3000, 32'h1234_5678); mid();
    check("t4_wr_gnt", bus.r0_gnt, 1'b1);
    check("t4_wr_we", bus.mem_we, 4'b0000);
    check("t4_wr_err", bus.r0_err, 1'b1);
    step(); idle(); mid();
    check("t4_wr_no_rvalid", bus.r0_rvalid, 1'b0);
    check("t4_err_clear", bus.r0_err, 1'b0);

    // Reset clears a partly-built starvation count and drops the in-flight read
    for (int i = 0; i < 3; i++) begin
      step();
      set0(1'b1, 1'b0, 4'hF, 32'h0000_0050, 32'h0);
      set1(1'b1, 1'b0, 4'hF, 32'h0000_0060, 32'h0);
      mid();
    end
    step(); rst = 1'b1; mid();
    check("t5_rst_r0_gnt", bus.r0_gnt, 1'b0);
    check("t5_rst_r1_gnt", bus.r1_gnt, 1'b0);
    check("t5_rst_en", bus.mem_en, 1'b0);
    check("t5_rst_rvalid", bus.r0_rvalid, 1'b0);
    step(); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      mid();
      r1p[i] = bus.r1_gnt;
    end
    check("t5_starve_cleared", r1p, 5'b10000);
    step(); idle(); mid();

    // DMA read granted, reset next cycle
    step(); set1(1'b1, 1'b0, 4'hF, 32'h0000_0040, 32'h0); mid();
    check("t6_r1_gnt", bus.r1_gnt, 1'b1);
    step(); rst = 1'b1;
    set0(1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
    set1(1'b1, 1'b0, 4'hF, 32'h0000_0040, 32'h0);
    mid();
    check("t6_r1_rvalid", bus.r1_rvalid, 1'b0);
    check("t6_r0_gnt", bus.r0_gnt, 1'b0);
    check("t6_r1_gnt", bus.r1_gnt, 1'b0);
    step(); rst = 1'b0; idle(); mid();
    check("t6_r1_rvalid_after", bus.r1_rvalid, 1'b0);

    // DMA partial write, then alternating reads
    step(); set1(1'b1, 1'b1, 4'b1001, 32'h0000_0104, 32'hAABB_CCDD); mid();
    step(); idle(); set0(1'b1, 1'b0, 4'hF, 32'h0000_0104, 32'h0); mid();
    step(); idle(); mid();
    check("t7_partial", bus.r0_rdata, 32'hAA00_00DD);
    for (int i = 0; i < 8; i++) begin
      step();
      idle();
      if (i % 2 == 0) set0(1'b1, 1'b0, 4'hF, 32'h0000_0100 + 32'(4 * i), 32'h0);
      else            set1(1'b1, 1'b0, 4'hF, 32'h0000_0200 + 32'(4 * i), 32'h0);
      mid();
      check("t7_both_rvalid", bus.r0_rvalid & bus.r1_rvalid, 1'b0);
      if (i == 3) check("t7_r0_rdata", bus.r0_rdata, 32'h1000_0042);
      if (i == 4) check("t7_r1_rdata", bus.r1_rdata, 32'h1000_0083);
    end
    step(); idle(); mid();
    step(); mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single-port data-memory RAM (12-bit word address, 4-bit byte-write enable, 1-cycle synchronous read) between two requesters.
  - Requester 0: pipeline EX/MEM load/store.
  - Requester 1: DMA/debug master.
- Sits between the Access stage and dm_ram.
- Generates the pipeline stall, returns read data one cycle after grant, and flags out-of-range accesses instead of touching RAM.
- Guarantees requester 1 forward progress with a bounded starvation counter.

Parameters:
- DM_LIMIT, 32'h0000_3000, first byte address (low 16 bits compared) outside data memory.
- STARVE_MAX, 4, consecutive cycles requester 1 may be denied while requesting before it wins priority (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- r0_req  in  1  pipeline request valid; held stable until r0_gnt.
- r0_we  in  1  pipeline write (1) / read (0).
- r0_be  in  4  pipeline byte enables.
- r0_addr  in  32  pipeline byte address.
- r0_wdata  in  32  pipeline write data, already lane-aligned.
- r0_gnt  out  1  pipeline request accepted this cycle.
- r0_stall  out  1  r0_req & ~r0_gnt.
- r0_rvalid  out  1  pipeline read data valid.
- r0_rdata  out  32  pipeline read data.
- r0_err  out  1  pipeline access was out of range; qualified by rvalid or by the write grant.
- r1_req, r1_we, r1_be, r1_addr, r1_wdata  in  1/1/4/32/32  DMA request, same rules as r0.
- r1_gnt, r1_rvalid, r1_rdata, r1_err  out  1/1/32/1  DMA responses, same rules as r0.
- mem_en  out  1  RAM enable.
- mem_we  out  4  RAM byte write enable.
- mem_addr  out  12  RAM word address = addr[13:2] of the winner.
- mem_din  out  32  RAM write data.
- mem_dout  in  32  RAM read data, valid the cycle after a read enable.

Behaviour:
- Reset (rst=1 at posedge):
  - starve_cnt=0.
  - Registered r0_rvalid=r1_rvalid=0, r0_err=r1_err=0, rd_owner=0, rd_oor=0.
  - Any read in flight is dropped; no rvalid follows.
  - While rst is high all grants and mem_en are 0.
- Arbitration is combinational within the cycle:
  - Requester 1 wins if r1_req & (~r0_req | starve_cnt==STARVE_MAX).
  - Otherwise requester 0 wins if r0_req.
  - At most one gnt per cycle; gnt implies acceptance.
- Starvation counter, updated at posedge:
  - r1_req & ~r1_gnt -> starve_cnt+1, saturating at STARVE_MAX.
  - r1_gnt or ~r1_req -> 0.
- Range check: oor = (winner addr[15:0] >= DM_LIMIT).
- Memory drive:
  - mem_en = grant & ~oor.
  - mem_we = {4{we & ~oor}} & be.
  - mem_din = wdata.
  - mem_addr is the winner's addr[13:2].
  - With no grant: mem_en=0, mem_we=0, address and data don't-care.
- Reads: on a granted read, rd_owner and rd_oor are registered. Next cycle:
  - The owner's rvalid=1 for exactly one cycle.
  - rdata = rd_oor ? 0 : mem_dout.
  - err = rd_oor.
  - The non-owner's rvalid=0 and rdata=0.
- Writes: no rvalid. err for a write is reported combinationally with gnt (oor) and suppresses the RAM write.
- Back-to-back: a new grant is allowed in the cycle rvalid is returned (full throughput, one access/cycle).
- Requesters may change signals only after gnt; behaviour is undefined otherwise.

Test Plan:
- Reset, then r0 read addr 0x0000_0010 with RAM word 4 = 0xDEADBEEF -> same cycle: r0_gnt=1, mem_en=1, mem_addr=4, mem_we=0. Next cycle: r0_rvalid=1, r0_rdata=0xDEADBEEF.
- r0 write be=4'b0100, addr 0x22, wdata 0x00AB0000 -> mem_we=4'b0100, mem_addr=8, no rvalid, r0_stall=0.
- r0 and r1 both requesting continuously, STARVE_MAX=4 -> r0 granted cycles 1-4, r1 granted cycle 5, r0_stall=1 in cycle 5, starve_cnt back to 0, pattern repeats.
- r0 read at 0x0000_3004 -> r0_gnt=1, mem_en=0; next cycle r0_rvalid=1, r0_err=1, r0_rdata=0. r0 write at 0x3000 -> mem_we=0 and r0_err=1 with gnt.
- r1 read granted, rst asserted the following cycle -> r1_rvalid stays 0, starve_cnt=0, all gnt=0 while rst=1.
- Alternating r0 read/r1 read every cycle for 8 cycles -> each rvalid lands on the correct requester one cycle after its gnt, rdata matches RAM contents, never both rvalid high.
